// File: rtl/tmds_decoder.sv
// Single-lane TMDS receive decoder: word alignment search, lock tracking and
// 10b->8b / control-token decode, three registered stages from input to output.
module tmds_decoder #(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 2048
) (
    input  logic       clk_hdmi,
    input  logic       rst_hdmi_n,
    input  logic [9:0] symbol_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int TW = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int RW = $clog2(LOCK_COUNT) + 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(SEARCH_TIMEOUT);
    localparam logic [RW-1:0] RUN_MAX   = RW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Returns {is_control, code}.
    function automatic logic [2:0] ctrl_decode(input logic [9:0] q);
        case (q)
            10'b1101010100: ctrl_decode = 3'b100;
            10'b0010101011: ctrl_decode = 3'b101;
            10'b0101010100: ctrl_decode = 3'b110;
            10'b1010101011: ctrl_decode = 3'b111;
            default:        ctrl_decode = 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] decode_data(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] o;
        d    = q[9] ? ~q[7:0] : q[7:0];
        o    = '0;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    logic [9:0]    prev_p0;
    logic          vld_p0;
    logic [19:0]   cat_p0;
    logic [9:0]    win_p0;
    logic [9:0]    q_p1;
    logic          vld_p1;
    logic [2:0]    cls_p1;
    logic          vld_p2;

    state_t        state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    offset_q, offset_d;
    logic          hit, miss, expire;

    assign cat_p0 = {symbol_in, prev_p0};
    assign win_p0 = cat_p0[{1'b0, offset_q} +: 10];
    assign cls_p1 = ctrl_decode(q_p1);

    // p0: previous word, p1: aligned window, p2: decoded outputs
    always_ff @(posedge clk_hdmi or negedge rst_hdmi_n) begin
        if (!rst_hdmi_n) begin
            prev_p0  <= '0;
            vld_p0   <= 1'b0;
            q_p1     <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            de       <= 1'b0;
            ctrl_out <= '0;
            data_out <= '0;
        end else begin
            prev_p0  <= symbol_in;
            vld_p0   <= 1'b1;
            q_p1     <= win_p0;
            vld_p1   <= vld_p0;
            vld_p2   <= vld_p1;
            de       <= ~cls_p1[2];
            ctrl_out <= cls_p1[2] ? cls_p1[1:0] : 2'b00;
            data_out <= decode_data(q_p1);
        end
    end

    // The FSM watches the registered output stage so lock status trails the
    // decoded symbol by one cycle; vld_p2 masks the post-reset fill.
    assign hit    = vld_p2 & ~de;
    assign miss   = vld_p2 & de;
    assign expire = (timer_q == TIMER_MAX) && !hit;

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        timer_d  = timer_q;
        offset_d = offset_q;
        if (hit) begin
            timer_d = '0;
        end else if (miss && (timer_q != TIMER_MAX)) begin
            timer_d = timer_q + 1'b1;
        end
        if (expire) begin
            state_d  = SEARCH;
            run_d    = '0;
            timer_d  = '0;
            offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (hit) begin
                        run_d   = RW'(1);
                        state_d = (RUN_MAX <= RW'(1)) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (hit) begin
                        run_d = run_q + 1'b1;
                        if ((run_q + 1'b1) >= RUN_MAX) state_d = LOCKED;
                    end else if (miss) begin
                        run_d   = '0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    state_d = LOCKED;
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_hdmi or negedge rst_hdmi_n) begin
        if (!rst_hdmi_n) begin
            state_q  <= SEARCH;
            run_q    <= '0;
            timer_q  <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            timer_q  <= timer_d;
            offset_q <= offset_d;
        end
    end

    assign locked = (state_q == LOCKED);
    assign offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: bytes are TMDS-encoded here, serialized with a chosen
// bit delay, and the decoder must return the original bytes and control codes.
module tb_tmds_decoder;

    localparam int TO = 2048;

    typedef struct packed {
        logic       ic;
        logic [1:0] c;
        logic [7:0] b;
    } ent_t;

    logic       clk_hdmi = 1'b0;
    logic       rst_hdmi_n = 1'b0;
    logic [9:0] symbol_in = '0;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de;
    logic       locked;
    logic [3:0] offset;

    int   cmp = 0;
    int   bad = 0;
    int   dly = 0;
    logic [9:0] carry = '0;
    ent_t hist[$];

    tmds_decoder #(.LOCK_COUNT(8), .SEARCH_TIMEOUT(TO)) dut (
        .clk_hdmi  (clk_hdmi),
        .rst_hdmi_n(rst_hdmi_n),
        .symbol_in (symbol_in),
        .data_out  (data_out),
        .ctrl_out  (ctrl_out),
        .de        (de),
        .locked    (locked),
        .offset    (offset)
    );

    always #5 clk_hdmi = ~clk_hdmi;

    function automatic logic [9:0] ctrl_word(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    // Transmit-side TMDS encoder; inv picks the DC-balance inversion freely.
    function automatic logic [9:0] tmds_encode(input logic [7:0] d, input logic inv);
        int n1;
        logic [8:0] qm;
        n1    = $countones(d);
        qm    = '0;
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    // Symbol starts dly bits into the word; remaining bits spill into the next word.
    task automatic send(input logic [9:0] sym, input logic ic, input logic [1:0] c,
                        input logic [7:0] b);
        logic [19:0] t;
        ent_t e;
        t = {sym, carry} >> (10 - dly);
        symbol_in = t[9:0];
        carry = sym;
        @(posedge clk_hdmi);
        #1;
        e.ic = ic; e.c = c; e.b = b;
        hist.push_back(e);
    endtask

    task automatic send_ctrl(input logic [1:0] c);
        send(ctrl_word(c), 1'b1, c, 8'h00);
    endtask

    task automatic send_data(input logic [7:0] b, input logic inv);
        send(tmds_encode(b, inv), 1'b0, 2'b00, b);
    endtask

    task automatic do_reset(input int d);
        rst_hdmi_n = 1'b0;
        symbol_in = '0;
        carry = '0;
        dly = d;
        hist.delete();
        repeat (3) @(posedge clk_hdmi);
        #1 rst_hdmi_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_hdmi_n = 1'b0;
        symbol_in = 10'h354;
        repeat (2) @(posedge clk_hdmi);
        #1;
        cmp++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
        cmp++; if (ctrl_out !== 2'b00) begin bad++; $display("FAIL reset_ctrl: got %b want 00", ctrl_out); end
        cmp++; if (de !== 1'b0) begin bad++; $display("FAIL reset_de: got %b want 0", de); end
        cmp++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        cmp++; if (offset !== 4'd0) begin bad++; $display("FAIL reset_offset: got %0d want 0", offset); end
        rst_hdmi_n = 1'b1;
        carry = '0; dly = 0; hist.delete();
        for (int s = 0; s < 6; s++) send_data(8'h00, 1'b0);
        cmp++; if (locked !== 1'b0 || offset !== 4'd0)
            begin bad++; $display("FAIL reset_idle: locked=%b offset=%0d want 0/0", locked, offset); end
    endtask

    task automatic test_offset0_lock();
        ent_t e;
        do_reset(0);
        for (int s = 1; s <= 12; s++) begin
            send_ctrl(2'b00);
            cmp++; if (locked !== (s >= 11))
                begin bad++; $display("FAIL lock0_locked s=%0d: got %b want %b", s, locked, s >= 11); end
        end
        for (int s = 0; s < 4; s++) begin
            if (s == 0) send_data(8'h00, 1'b0);
            else if (s == 1) send_data(8'hFF, 1'b1);
            else send_ctrl(2'b00);
            e = hist[hist.size()-3];
            cmp++;
            if (e.ic ? (de !== 1'b0 || ctrl_out !== e.c) : (de !== 1'b1 || data_out !== e.b)) begin
                bad++;
                $display("FAIL lock0_out s=%0d: de=%b ctrl=%b data=%h want ctrl=%b code=%b data=%h",
                         s, de, ctrl_out, data_out, e.ic, e.c, e.b);
            end
        end
        cmp++; if (offset !== 4'd0 || locked !== 1'b1)
            begin bad++; $display("FAIL lock0_state: offset=%0d locked=%b want 0/1", offset, locked); end
    endtask

    task automatic test_ctrl_codes();
        ent_t e;
        for (int s = 0; s < 6; s++) begin
            send_ctrl((s < 4) ? 2'(s) : 2'b00);
            if (s >= 2) begin
                e = hist[hist.size()-3];
                cmp++;
                if (de !== 1'b0 || ctrl_out !== e.c || locked !== 1'b1) begin
                    bad++;
                    $display("FAIL ctrl_codes s=%0d: de=%b ctrl=%b locked=%b want 0/%b/1",
                             s, de, ctrl_out, locked, e.c);
                end
            end
        end
    endtask

    task automatic test_random_data();
        ent_t e;
        logic [7:0] b;
        for (int s = 0; s < 300; s++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) send_ctrl(2'($urandom_range(0, 3)));
            else send_data(b, 1'($urandom_range(0, 1)));
            e = hist[hist.size()-3];
            cmp++;
            if (locked !== 1'b1 ||
                (e.ic ? (de !== 1'b0 || ctrl_out !== e.c) : (de !== 1'b1 || data_out !== e.b))) begin
                bad++;
                $display("FAIL random s=%0d: locked=%b de=%b ctrl=%b data=%h want ctrl=%b code=%b data=%h",
                         s, locked, de, ctrl_out, data_out, e.ic, e.c, e.b);
            end
        end
    endtask

    task automatic test_timeout_hold();
        send_ctrl(2'b00);
        for (int j = 1; j <= 2056; j++) begin
            if (j == TO + 1) send_ctrl(2'b01);
            else send_data(8'h00, 1'b0);
            cmp++; if (locked !== 1'b1 || offset !== 4'd0)
                begin bad++; $display("FAIL hold_on_limit j=%0d: locked=%b offset=%0d want 1/0", j, locked, offset); end
        end
    endtask

    task automatic test_search_delay3();
        ent_t e;
        logic [3:0] prev_off;
        int n, last, changes;
        do_reset(3);
        prev_off = 4'd0; n = 0; last = 0; changes = 0;
        while (offset !== 4'd3 && n < 8000) begin
            send_ctrl(2'b00);
            n++;
            if (offset !== prev_off) begin
                cmp++; if (offset !== prev_off + 4'd1 || locked !== 1'b0)
                    begin bad++; $display("FAIL search_step: offset=%0d locked=%b want %0d/0", offset, locked, prev_off + 4'd1); end
                if (changes > 0) begin
                    cmp++; if (n - last != TO + 1)
                        begin bad++; $display("FAIL search_interval: got %0d want %0d", n - last, TO + 1); end
                end
                changes++; last = n; prev_off = offset;
            end
        end
        cmp++; if (offset !== 4'd3) begin bad++; $display("FAIL search_reach: offset=%0d want 3", offset); end
        n = 0;
        while (locked !== 1'b1 && n < 40) begin send_ctrl(2'b00); n++; end
        cmp++; if (locked !== 1'b1 || offset !== 4'd3)
            begin bad++; $display("FAIL search_lock: locked=%b offset=%0d want 1/3", locked, offset); end
        for (int s = 0; s < 100; s++) begin
            if ((s % 5) == 0) send_ctrl(2'($urandom_range(0, 3)));
            else send_data(8'($urandom), 1'($urandom_range(0, 1)));
            e = hist[hist.size()-3];
            cmp++;
            if (e.ic ? (de !== 1'b0 || ctrl_out !== e.c) : (de !== 1'b1 || data_out !== e.b)) begin
                bad++;
                $display("FAIL delay3_out s=%0d: de=%b ctrl=%b data=%h want ctrl=%b code=%b data=%h",
                         s, de, ctrl_out, data_out, e.ic, e.c, e.b);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int n;
        do_reset(5);
        n = 0;
        while (offset !== 4'd5 && n < 14000) begin send_ctrl(2'b00); n++; end
        n = 0;
        while (locked !== 1'b1 && n < 40) begin send_ctrl(2'b00); n++; end
        for (int s = 0; s < 3; s++) send_data(8'hA5, 1'b0);
        cmp++; if (locked !== 1'b1 || offset !== 4'd5 || data_out !== 8'hA5 || de !== 1'b1)
            begin bad++; $display("FAIL mid_prelock: locked=%b offset=%0d data=%h de=%b want 1/5/a5/1", locked, offset, data_out, de); end
        #2 rst_hdmi_n = 1'b0;
        #1;
        cmp++; if (data_out !== 8'h00 || ctrl_out !== 2'b00 || de !== 1'b0 || locked !== 1'b0 || offset !== 4'd0)
            begin bad++; $display("FAIL mid_async: data=%h ctrl=%b de=%b locked=%b offset=%0d want all 0", data_out, ctrl_out, de, locked, offset); end
        repeat (2) @(posedge clk_hdmi);
        #1 rst_hdmi_n = 1'b1;
        carry = '0; dly = 0; hist.delete();
        for (int s = 0; s < 5; s++) send_data(8'h00, 1'b0);
        cmp++; if (locked !== 1'b0 || offset !== 4'd0)
            begin bad++; $display("FAIL mid_release: locked=%b offset=%0d want 0/0", locked, offset); end
    endtask

    task automatic test_timeout_unlock();
        int n;
        do_reset(9);
        n = 0;
        while (offset !== 4'd9 && n < 20000) begin send_ctrl(2'b00); n++; end
        n = 0;
        while (locked !== 1'b1 && n < 40) begin send_ctrl(2'b00); n++; end
        cmp++; if (locked !== 1'b1 || offset !== 4'd9)
            begin bad++; $display("FAIL unlock_prelock: locked=%b offset=%0d want 1/9", locked, offset); end
        send_ctrl(2'b00);
        send_ctrl(2'b00);
        for (int j = 1; j <= TO + 8; j++) begin
            send_data(8'h00, 1'b0);
            cmp++; if (locked !== (j < TO + 4) || offset !== ((j < TO + 4) ? 4'd9 : 4'd0))
                begin bad++; $display("FAIL unlock_timing j=%0d: locked=%b offset=%0d want %b/%0d", j, locked, offset, j < TO + 4, (j < TO + 4) ? 9 : 0); end
        end
    endtask

    task automatic test_abort_relock();
        int n;
        do_reset(2);
        n = 0;
        while (offset !== 4'd2 && n < 6000) begin send_data(8'h00, 1'b0); n++; end
        cmp++; if (offset !== 4'd2 || locked !== 1'b0)
            begin bad++; $display("FAIL abort_reach: offset=%0d locked=%b want 2/0", offset, locked); end
        for (int s = 1; s <= 18; s++) begin
            if (s == 6) send_data(8'h00, 1'b0);
            else send_ctrl(2'b00);
            cmp++; if (locked !== (s >= 17))
                begin bad++; $display("FAIL abort_locked s=%0d: got %b want %b", s, locked, s >= 17); end
        end
        cmp++; if (offset !== 4'd2) begin bad++; $display("FAIL abort_offset: got %0d want 2", offset); end
    endtask

    initial begin
        test_reset();
        test_offset0_lock();
        test_ctrl_codes();
        test_random_data();
        test_timeout_hold();
        test_search_delay3();
        test_reset_midstream();
        test_timeout_unlock();
        test_abort_relock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
